reg_file_bank: RTL and testbench
================================

# reg_file_bank

Architectural register file for the 32-bit RISC-V pipeline. It is the responder on the decode stage's register interface: two combinational read ports addressed by rs1/rs2, and one clocked write port driven by writeback. A handshaked dump engine streams all 32 registers to the testbench or debug logic for end-of-test state comparison.

## Interface
- SP_RESET, 32'h0000_0000, reset value of x2 (stack pointer); all other registers reset to 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr1  in  32  rs1 address from decode; only bits [4:0] are used, [31:5] ignored.
- rd_addr2  in  32  rs2 address from decode; only bits [4:0] are used, [31:5] ignored.
- rd_data1  out  32  value of register rd_addr1[4:0].
- rd_data2  out  32  value of register rd_addr2[4:0].
- wr_en  in  1  writeback write enable (op_write).
- wr_addr  in  32  destination register; only bits [4:0] are used.
- wr_data  in  32  writeback data.
- dump_req  in  1  single-cycle start pulse for a register dump.
- dump_ready  in  1  sink accepts the current dump beat.
- dump_valid  out  1  dump beat present.
- dump_idx  out  5  register index of the current beat.
- dump_data  out  32  register value of the current beat.
- dump_done  out  1  single-cycle pulse after the last beat is accepted.
- busy  out  1  high while the dump engine is not IDLE.

## Operation
- Storage: 32 x 32-bit flops. x0 reads as 0 at all times. Writes to x0 are dropped.
- Write: when wr_en=1 and wr_addr[4:0]!=0, reg[wr_addr[4:0]] <= wr_data at posedge clk.
- Read: combinational. If wr_en=1 and wr_addr[4:0]==rd_addrN[4:0]!=0, rd_dataN = wr_data (write-before-read bypass). Otherwise rd_dataN = reg[rd_addrN[4:0]].
- Dump FSM states:
  - IDLE: dump_req=1 -> DUMP, with dump_idx<=0 and dump_data<=0 (x0). dump_req is ignored in every other state.
  - DUMP: dump_valid=1. dump_idx and dump_data are registered and hold stable while dump_ready=0.
    - On valid&ready with dump_idx<31: dump_idx <= dump_idx+1, and dump_data <= the bypassed read of index dump_idx+1. The bypassed read includes a same-cycle write.
    - On valid&ready with dump_idx==31: -> DONE.
  - DONE: dump_valid=0, dump_done=1 for exactly one cycle, then -> IDLE.
- busy = (state != IDLE).
- Writes proceed normally during a dump. A beat already presented is not updated by a later write to its register.

## Timing
- Reset values: all registers 0 except x2 = SP_RESET; state IDLE; dump_valid=0, dump_idx=0, dump_data=0, dump_done=0, busy=0.
- rd_data1/rd_data2 are valid combinationally in the same cycle as the address.
- A write is visible through the array from the cycle after posedge. It is visible via bypass in the same cycle.
- First beat (dump_valid=1, idx 0) appears the cycle after dump_req. With dump_ready held high, the dump takes 32 beat cycles. dump_done is asserted in the cycle after the idx-31 handshake, i.e. 33 cycles after dump_req. busy drops the cycle after that.
- Stalls: each dump_ready=0 cycle adds one cycle. dump_idx and dump_data do not change during a stall.
- Reset asserted mid-dump: the FSM goes to IDLE immediately and all outputs and registers take their reset values. No dump_done is produced.
- dump_req asserted in the same cycle as dump_done: ignored.

## Test plan
- Reset with SP_RESET=32'h0000_FFF0: read all 32 addresses. Response: x2=32'h0000_FFF0, others 0, busy=0.
- Write x5=32'hDEAD_BEEF while rd_addr1=5 in the same cycle. Response: rd_data1=32'hDEAD_BEEF that cycle and after. Write x0=32'h1234 with rd_addr2=0. Response: rd_data2 stays 0.
- Write x7=32'h11 with rd_addr1=32'h0000_0027 (upper bits set). Response: rd_data1=32'h11.
- Load xi=i*16 for i=1..31, pulse dump_req, hold dump_ready=1. Response: 32 beats idx 0..31 with data 0,16,...,496 (x2=32). dump_done is a single pulse at cycle 33; busy is low at cycle 34.
- Start a dump, drop dump_ready for 3 cycles at idx 4, and write x4=32'hAAAA during the stall. Response: idx=4 and data=64 held through the stall. Write x6=32'h55 in the same cycle as the idx-5 handshake. Response: the idx-6 beat shows 32'h55.
- Assert reset_n=0 at idx 10 of a dump. Response: dump_valid=0, busy=0, all registers reset, no dump_done. A new dump_req after reset restarts from idx 0.

Source files
------------

// File: rtl/reg_file_bank.sv
// Architectural register file: 31 writable 32-bit registers plus hard-wired x0,
// two combinational bypassed read ports, and a handshaked full-state dump engine.
module reg_file_bank #(
    parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rd_addr1,
    input  logic [31:0] rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        dump_req,
    input  logic        dump_ready,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        dump_done,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ports 0/1 serve decode; port 2 pre-reads the next dump beat.
    localparam int N_PORTS = 3;

    logic [31:0] r_regs [1:31];
    logic [31:0] w_regs [0:31];

    logic [1:0]  r_state;
    logic [4:0]  r_dump_idx;
    logic [31:0] r_dump_data;

    logic [4:0]  w_wr_idx;
    logic        w_wr_active;
    logic [4:0]  w_port_idx  [0:N_PORTS-1];
    logic        w_port_hit  [0:N_PORTS-1];
    logic [31:0] w_port_data [0:N_PORTS-1];
    logic        w_unused_addr_bits;

    assign w_wr_idx    = wr_addr[4:0];
    assign w_wr_active = wr_en && (w_wr_idx != 5'd0);

    assign w_port_idx[0] = rd_addr1[4:0];
    assign w_port_idx[1] = rd_addr2[4:0];
    // Wraps to 0 at idx 31, where the pre-read value is never captured.
    assign w_port_idx[2] = r_dump_idx + 5'd1;

    assign w_unused_addr_bits = ^{rd_addr1[31:5], rd_addr2[31:5], wr_addr[31:5]};

    assign w_regs[0] = 32'd0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg_view
            assign w_regs[gi] = r_regs[gi];
        end

        // A same-cycle write to the addressed register wins over the stored value.
        for (gi = 0; gi < N_PORTS; gi++) begin : g_read_port
            assign w_port_hit[gi]  = w_wr_active && (w_wr_idx == w_port_idx[gi]);
            assign w_port_data[gi] = w_port_hit[gi] ? wr_data : w_regs[w_port_idx[gi]];
        end
    endgenerate

    assign rd_data1 = w_port_data[0];
    assign rd_data2 = w_port_data[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= (i == 2) ? SP_RESET : 32'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_en && (w_wr_idx == 5'(i))) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Beat data is captured once per handshake, so later writes do not disturb a presented beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_dump_idx  <= 5'd0;
            r_dump_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dump_req) begin
                        r_state     <= ST_DUMP;
                        r_dump_idx  <= 5'd0;
                        r_dump_data <= 32'd0;
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (r_dump_idx == 5'd31) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_dump_idx  <= w_port_idx[2];
                            r_dump_data <= w_port_data[2];
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dump_valid = (r_state == ST_DUMP);
    assign dump_done  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign dump_idx   = r_dump_idx;
    assign dump_data  = r_dump_data;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed self-checking bench for reg_file_bank: reset state, bypassed reads,
// full dump, stalled dump with concurrent writes, and reset during a dump.
module tb_reg_file_bank;

    localparam logic [31:0] SP_VAL = 32'h0000_FFF0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rd_addr1, rd_addr2, rd_data1, rd_data2;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        dump_req, dump_ready, dump_valid, dump_done, busy;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_bank #(.SP_RESET(SP_VAL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .busy       (busy)
    );

    task automatic test_reset();
        logic [31:0] exp1, exp2;
        reset_n = 1'b1; rd_addr1 = 0; rd_addr2 = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        dump_req = 0; dump_ready = 0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_tests++;
        if ({dump_valid, dump_idx, dump_data, dump_done, busy} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {dump_valid, dump_idx, dump_data, dump_done, busy}, 40'd0);
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr1 = a;
            rd_addr2 = 31 - a;
            #1;
            exp1 = (a == 2) ? SP_VAL : 32'd0;
            exp2 = (31 - a == 2) ? SP_VAL : 32'd0;
            n_tests++;
            if (rd_data1 !== exp1 || rd_data2 !== exp2) begin
                n_fail++;
                $display("FAIL reset_read x%0d/x%0d: got %h/%h expected %h/%h",
                         a, 31 - a, rd_data1, rd_data2, exp1, exp2);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; rd_addr1 = 5; rd_addr2 = 2;
        #1;
        n_tests++;
        if (rd_data1 !== 32'hDEAD_BEEF || rd_data2 !== SP_VAL) begin
            n_fail++;
            $display("FAIL bypass_x5: got %h/%h expected deadbeef/%h", rd_data1, rd_data2, SP_VAL);
        end
        @(negedge clk);
        wr_en = 0;
        #1;
        n_tests++;
        if (rd_data1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL stored_x5: got %h expected deadbeef", rd_data1);
        end
        @(negedge clk);
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr2 = 0;
        #1;
        n_tests++;
        if (rd_data2 !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_bypass: got %h expected 0", rd_data2);
        end
        @(negedge clk);
        wr_en = 0;
        #1;
        n_tests++;
        if (rd_data2 !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_stored: got %h expected 0", rd_data2);
        end
        @(negedge clk);
        wr_en = 1; wr_addr = 7; wr_data = 32'h11; rd_addr1 = 32'h0000_0027;
        #1;
        n_tests++;
        if (rd_data1 !== 32'h11) begin
            n_fail++;
            $display("FAIL upper_bits_bypass: got %h expected 11", rd_data1);
        end
        @(negedge clk);
        wr_en = 1; wr_addr = 32'hFFFF_FFE9; wr_data = 32'h9999; rd_addr1 = 32'h0000_0027;
        rd_addr2 = 9;
        #1;
        n_tests++;
        if (rd_data1 !== 32'h11 || rd_data2 !== 32'h9999) begin
            n_fail++;
            $display("FAIL upper_bits_stored: got %h/%h expected 11/9999", rd_data1, rd_data2);
        end
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic test_dump_full();
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1; wr_addr = i; wr_data = i * 16;
        end
        @(negedge clk);
        wr_en = 0; dump_req = 1; dump_ready = 1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            dump_req = (c == 33);
            #1;
            n_tests++;
            if (c <= 32) begin
                if ({dump_valid, dump_idx, dump_data, dump_done, busy} !==
                    {1'b1, 5'(c - 1), 32'((c - 1) * 16), 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL dump_beat c%0d: got v%b i%0d d%h done%b busy%b expected idx %0d data %h",
                             c, dump_valid, dump_idx, dump_data, dump_done, busy, c - 1, (c - 1) * 16);
                end
            end else if (c == 33) begin
                if ({dump_valid, dump_done, busy} !== 3'b011) begin
                    n_fail++;
                    $display("FAIL dump_done_c33: got v%b done%b busy%b expected v0 done1 busy1",
                             dump_valid, dump_done, busy);
                end
            end else begin
                if ({dump_valid, dump_done, busy} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL dump_idle_c%0d: got v%b done%b busy%b expected all 0",
                             c, dump_valid, dump_done, busy);
                end
            end
        end
    endtask

    task automatic test_stall_and_writes();
        @(negedge clk);
        dump_req = 1; dump_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dump_req = 0;
            #1;
            n_tests++;
            if (dump_idx !== 5'(k) || dump_data !== 32'(k * 16)) begin
                n_fail++;
                $display("FAIL stall_pre idx%0d: got i%0d d%h expected data %h", k, dump_idx, dump_data, k * 16);
            end
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            wr_en = (s == 1); wr_addr = 4; wr_data = 32'hAAAA; rd_addr1 = 4;
            dump_ready = (s == 3);
            #1;
            n_tests++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'd4 || dump_data !== 32'd64) begin
                n_fail++;
                $display("FAIL stall_hold s%0d: got v%b i%0d d%h expected v1 i4 d40",
                         s, dump_valid, dump_idx, dump_data);
            end
        end
        n_tests++;
        if (rd_data1 !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL stall_write_x4: got %h expected aaaa", rd_data1);
        end
        @(negedge clk);
        wr_en = 1; wr_addr = 6; wr_data = 32'h55;
        #1;
        n_tests++;
        if (dump_idx !== 5'd5 || dump_data !== 32'd80) begin
            n_fail++;
            $display("FAIL stall_idx5: got i%0d d%h expected i5 d50", dump_idx, dump_data);
        end
        @(negedge clk);
        wr_en = 0;
        #1;
        n_tests++;
        if (dump_idx !== 5'd6 || dump_data !== 32'h55) begin
            n_fail++;
            $display("FAIL stall_idx6_bypass: got i%0d d%h expected i6 d55", dump_idx, dump_data);
        end
        for (int k = 7; k < 32; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (dump_idx !== 5'(k) || dump_data !== 32'(k * 16)) begin
                n_fail++;
                $display("FAIL stall_post idx%0d: got i%0d d%h expected data %h", k, dump_idx, dump_data, k * 16);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: got done%b v%b expected done1 v0", dump_done, dump_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || dump_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: got busy%b done%b expected 0/0", busy, dump_done);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] exp1;
        @(negedge clk);
        dump_req = 1; dump_ready = 1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            dump_req = 0;
        end
        #1;
        n_tests++;
        if (dump_idx !== 5'd10 || dump_data !== 32'd160) begin
            n_fail++;
            $display("FAIL mid_dump_idx10: got i%0d d%h expected i10 da0", dump_idx, dump_data);
        end
        reset_n = 0;
        #1;
        n_tests++;
        if ({dump_valid, dump_idx, dump_data, dump_done, busy} !== 40'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected %h",
                     {dump_valid, dump_idx, dump_data, dump_done, busy}, 40'd0);
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr1 = a;
            #1;
            exp1 = (a == 2) ? SP_VAL : 32'd0;
            n_tests++;
            if (rd_data1 !== exp1 || dump_done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_reg x%0d: got %h done%b expected %h done0", a, rd_data1, dump_done, exp1);
            end
        end
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (dump_done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet c%0d: got done%b busy%b expected 0/0", c, dump_done, busy);
            end
        end
        dump_req = 1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            dump_req = 0;
            #1;
            n_tests++;
            if (c <= 32) begin
                exp1 = (c - 1 == 2) ? SP_VAL : 32'd0;
                if (dump_valid !== 1'b1 || dump_idx !== 5'(c - 1) || dump_data !== exp1) begin
                    n_fail++;
                    $display("FAIL redump c%0d: got v%b i%0d d%h expected v1 i%0d d%h",
                             c, dump_valid, dump_idx, dump_data, c - 1, exp1);
                end
            end else if (dump_done !== 1'b1) begin
                n_fail++;
                $display("FAIL redump_done: got %b expected 1", dump_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_dump_full();
        test_stall_and_writes();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
